// File: rtl/dom_rng_pkg.sv
// Shared types, constants and the LFSR step function for the DOM fresh-randomness source.
package dom_rng_pkg;

    localparam int LFSR_W = 32;

    // Tap mask for x^32 + x^22 + x^2 + x + 1: state bits 31, 21, 1 and 0.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

    localparam logic [LFSR_W-1:0] ZERO_SEED = 32'hACE1_0001;

    typedef enum logic [1:0] {
        UNSEEDED = 2'd0,
        LOAD     = 2'd1,
        WARM     = 2'd2,
        RUN      = 2'd3
    } rng_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dom_rng_lane.sv
// One 32-bit Fibonacci LFSR lane with seed load, step enable and zero-seed substitution.
module dom_rng_lane
    import dom_rng_pkg::*;
#(
    parameter int IDX = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic              msb
);

    logic [LFSR_W-1:0] s;
    logic [LFSR_W-1:0] guarded;

    // An all-zero LFSR would lock up, so a zero seed is replaced by a lane-unique constant.
    assign guarded = (seed == '0) ? (ZERO_SEED ^ LFSR_W'(IDX)) : seed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s <= '0;
        end else if (load) begin
            s <= guarded;
        end else if (step) begin
            s <= lfsr_step(s);
        end
    end

    assign msb = s[LFSR_W-1];

endmodule

// File: rtl/dom_rng.sv
// Fresh-randomness source for DOM AND gadgets: LANES parallel LFSRs, seeded word by word,
// warmed up, then advanced only when the consumer accepts a value.
module dom_rng
    import dom_rng_pkg::*;
#(
    parameter  int D      = 2,
    parameter  int W      = 1,
    parameter  int WARMUP = 64,
    localparam int Z      = D * (D - 1) / 2,
    localparam int LANES  = Z * W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      seed_i,
    input  logic             seed_valid_i,
    output logic             seed_ready_o,
    output logic [LANES-1:0] rnd_o,
    output logic             rnd_valid_o,
    input  logic             rnd_ready_i,
    output logic             busy_o,
    output rng_state_e       fsm_state
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);

    rng_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             seed_fire;
    logic             rnd_fire;
    logic             restart;
    logic             step_all;
    logic [LANES-1:0] load_en;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Valid may not drop and data may not change until the transfer has happened.
    assign seed_fire = seed_valid_i & seed_ready_o;
    assign rnd_fire  = rnd_valid_o & rnd_ready_i;
    assign restart   = seed_fire && (state_q == UNSEEDED || state_q == RUN);

    // A reseed in RUN wins over the concurrent draw: the draw completes but the lanes do not step.
    assign step_all  = (state_q == WARM && cnt_q != '0)
                     || (state_q == RUN && rnd_fire && !seed_fire);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= UNSEEDED;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            UNSEEDED, RUN: begin
                if (seed_fire) begin
                    idx_d = IDX_W'(1);
                    if (LANES == 1) begin
                        state_d = WARM;
                        cnt_d   = CNT_W'(WARMUP);
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (seed_fire) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = WARM;
                        cnt_d   = CNT_W'(WARMUP);
                    end
                end
            end
            WARM: begin
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = UNSEEDED;
        endcase
    end

    // All status outputs decode the state register only, so rnd_ready_i never reaches them.
    always_comb begin
        seed_ready_o = (state_q != WARM);
        rnd_valid_o  = (state_q == RUN);
        busy_o       = (state_q == LOAD) || (state_q == WARM);
        fsm_state    = state_q;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign load_en[i] = (restart && (i == 0))
                          || (seed_fire && state_q == LOAD && idx_q == IDX_W'(i));

        dom_rng_lane #(
            .IDX (i)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .load (load_en[i]),
            .step (step_all),
            .seed (seed_i),
            .msb  (rnd_o[i])
        );
    end

endmodule
